// File: rtl/lock_controller.sv
// ---------------------------------------------------------------------------
// lock_controller
//   Sequencing controller for the combination-lock datapath. It takes one
//   decimal digit per strobe and compares a DIGITS-long entry against the
//   stored code. It counts consecutive failures and, after MAX_FAIL of them,
//   holds a timed lockout. It drives the message selector for the
//   seven-segment decoder.
//   Optional feature macro: LOCK_PROG_EN (code reprogramming from OPEN).
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module lock_controller #(
  parameter int DIGITS         = 6,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       clear,
  input  logic       prog_req,
  output logic [2:0] msg,
  output logic [3:0] show_digit,
  output logic [2:0] pos,
  output logic [1:0] fail_cnt,
  output logic       unlocked,
  output logic       err
);

  localparam int CODE_W = DIGITS * 4;
  localparam int LCW    = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [2:0] MSG_BLANK  = 3'd0;
  localparam logic [2:0] MSG_DIGIT  = 3'd1;
  localparam logic [2:0] MSG_OPEN   = 3'd2;
  localparam logic [2:0] MSG_CLOSED = 3'd3;
  localparam logic [2:0] MSG_ERROR  = 3'd4;
  localparam logic [2:0] MSG_LOCKED = 3'd5;
`ifdef LOCK_PROG_EN
  localparam logic [2:0] MSG_PROG   = 3'd6;
`endif

  // Factory code 7,0,3,2,6,2; digit 0 lives in the lowest nibble.
  function automatic logic [CODE_W-1:0] default_code();
    logic [23:0] base;
    base = {4'd2, 4'd6, 4'd2, 4'd3, 4'd0, 4'd7};
    default_code = '0;
    for (int i = 0; i < DIGITS; i++) begin
      default_code[i*4 +: 4] = base[(i % 6)*4 +: 4];
    end
  endfunction

  localparam logic [CODE_W-1:0] C_DEFAULT_CODE = default_code();

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTER,
    ST_OPEN,
    ST_CLOSED,
    ST_LOCKOUT
`ifdef LOCK_PROG_EN
    , ST_PROG
`endif
  } state_t;

  state_t             state_q;
  logic [CODE_W-1:0]  code_q;
  logic [LCW-1:0]     lock_cnt_q;
  logic               mismatch_q;
  logic [2:0]         msg_q;
  logic [3:0]         show_digit_q;
  logic [2:0]         pos_q;
  logic [1:0]         fail_cnt_q;
  logic               unlocked_q;
  logic               err_q;
`ifdef LOCK_PROG_EN
  logic [CODE_W-5:0]  shadow_q;
`else
  logic               unused_prog_req;
  assign unused_prog_req = prog_req;
`endif

  logic       digit_legal;
  logic [3:0] exp_digit;
  logic       pos_last;
  logic       mismatch_in;
  logic [2:0] fail_next;
  logic       fail_hit;

  // Steady-state message for each state; the ERROR override is layered on top.
  function automatic logic [2:0] msg_of(input state_t s);
    case (s)
      ST_IDLE:    msg_of = MSG_BLANK;
      ST_ENTER:   msg_of = MSG_DIGIT;
      ST_OPEN:    msg_of = MSG_OPEN;
      ST_CLOSED:  msg_of = MSG_CLOSED;
      ST_LOCKOUT: msg_of = MSG_LOCKED;
`ifdef LOCK_PROG_EN
      ST_PROG:    msg_of = MSG_PROG;
`endif
      default:    msg_of = MSG_BLANK;
    endcase
  endfunction

  assign digit_legal = (digit <= 4'd9);
  assign pos_last    = (pos_q == 3'(DIGITS - 1));
  assign mismatch_in = mismatch_q | (digit != exp_digit);
  assign fail_next   = {1'b0, fail_cnt_q} + 3'd1;
  assign fail_hit    = (fail_next >= 3'(MAX_FAIL));

  // Select the stored code digit that the next entered digit is compared against.
  always_comb begin
    exp_digit = code_q[3:0];
    for (int i = 0; i < DIGITS; i++) begin
      if (pos_q == 3'(i)) exp_digit = code_q[i*4 +: 4];
    end
  end

  // Main sequencer: state, code storage and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= ST_IDLE;
      code_q       <= C_DEFAULT_CODE;
      lock_cnt_q   <= '0;
      mismatch_q   <= 1'b0;
      msg_q        <= MSG_BLANK;
      show_digit_q <= 4'd0;
      pos_q        <= 3'd0;
      fail_cnt_q   <= 2'd0;
      unlocked_q   <= 1'b0;
      err_q        <= 1'b0;
`ifdef LOCK_PROG_EN
      shadow_q     <= '0;
`endif
    end else begin
      // ERROR only lasts one cycle; otherwise the message follows the state.
      err_q <= 1'b0;
      msg_q <= msg_of(state_q);
      if (state_q == ST_LOCKOUT) begin
        // Lockout ignores every input until the counter runs out.
        if (lock_cnt_q == '0) begin
          state_q    <= ST_IDLE;
          msg_q      <= MSG_BLANK;
          fail_cnt_q <= 2'd0;
          pos_q      <= 3'd0;
        end else begin
          lock_cnt_q <= lock_cnt_q - 1'b1;
        end
      end else if (clear) begin
        state_q    <= ST_IDLE;
        msg_q      <= MSG_BLANK;
        pos_q      <= 3'd0;
        mismatch_q <= 1'b0;
        unlocked_q <= 1'b0;
`ifdef LOCK_PROG_EN
      end else if (prog_req && (state_q == ST_OPEN)) begin
        state_q <= ST_PROG;
        msg_q   <= MSG_PROG;
        pos_q   <= 3'd0;
`endif
      end else if (digit_valid) begin
        if (!digit_legal) begin
          err_q <= 1'b1;
          msg_q <= MSG_ERROR;
        end else begin
          case (state_q)
            ST_IDLE, ST_ENTER: begin
              show_digit_q <= digit;
              if (pos_last) begin
                // Verdict is taken on the same edge as the final digit.
                pos_q      <= 3'(DIGITS);
                mismatch_q <= 1'b0;
                if (!mismatch_in) begin
                  state_q    <= ST_OPEN;
                  msg_q      <= MSG_OPEN;
                  unlocked_q <= 1'b1;
                  fail_cnt_q <= 2'd0;
                end else if (fail_hit) begin
                  state_q    <= ST_LOCKOUT;
                  msg_q      <= MSG_LOCKED;
                  fail_cnt_q <= 2'(MAX_FAIL);
                  lock_cnt_q <= LCW'(LOCKOUT_CYCLES - 1);
                end else begin
                  state_q    <= ST_CLOSED;
                  msg_q      <= MSG_CLOSED;
                  fail_cnt_q <= fail_next[1:0];
                end
              end else begin
                state_q    <= ST_ENTER;
                msg_q      <= MSG_DIGIT;
                pos_q      <= pos_q + 3'd1;
                mismatch_q <= mismatch_in;
              end
            end
`ifdef LOCK_PROG_EN
            ST_PROG: begin
              show_digit_q <= digit;
              if (pos_last) begin
                // The final digit goes straight into the top nibble of the new code.
                code_q     <= {digit, shadow_q};
                state_q    <= ST_IDLE;
                msg_q      <= MSG_BLANK;
                pos_q      <= 3'd0;
                unlocked_q <= 1'b0;
              end else begin
                for (int i = 0; i < DIGITS - 1; i++) begin
                  if (pos_q == 3'(i)) shadow_q[i*4 +: 4] <= digit;
                end
                pos_q <= pos_q + 3'd1;
              end
            end
`endif
            default: begin
            end
          endcase
        end
      end
    end
  end

  assign msg        = msg_q;
  assign show_digit = show_digit_q;
  assign pos        = pos_q;
  assign fail_cnt   = fail_cnt_q;
  assign unlocked   = unlocked_q;
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_lock_controller.sv
// ---------------------------------------------------------------------------
// tb_lock_controller
//   Scoreboard bench for lock_controller. Each driven cycle is run through a
//   behavioural reference model. The model's expected outputs are queued,
//   then popped and compared after the corresponding clock edge.
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lock_controller;

`ifdef LOCK_PROG_EN
  localparam bit PROG_EN = 1'b1;
`else
  localparam bit PROG_EN = 1'b0;
`endif

  localparam int M_IDLE = 0, M_ENTER = 1, M_OPEN = 2, M_CLOSED = 3, M_LOCK = 4, M_PROG = 5;

  logic       clk;
  logic       rst;
  logic       dv;
  logic [3:0] d;
  logic       clr;
  logic       pr;
  logic [2:0] msg;
  logic [3:0] show_digit;
  logic [2:0] pos;
  logic [1:0] fail_cnt;
  logic       unlocked;
  logic       err;

  lock_controller #(.DIGITS(6), .MAX_FAIL(3), .LOCKOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst),
    .digit_valid(dv),
    .digit      (d),
    .clear      (clr),
    .prog_req   (pr),
    .msg        (msg),
    .show_digit (show_digit),
    .pos        (pos),
    .fail_cnt   (fail_cnt),
    .unlocked   (unlocked),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] msg;
    logic [3:0] sd;
    logic [2:0] pos;
    logic [1:0] fc;
    logic       un;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_mis  = 0;
  int   n_step = 0;

  // Reference model state
  int         m_st;
  int         m_pos;
  int         m_fail;
  int         m_lk;
  logic [3:0] m_sd;
  bit         m_err;
  logic [3:0] m_code  [6];
  logic [3:0] m_entry [6];
  logic [3:0] m_shadow[6];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_mis++;
      $display("FAIL %s at step %0d: got %0d, expected %0d", tag, n_step, obs, expv);
    end
  endtask

  task automatic model(input bit r, input bit v, input logic [3:0] dd, input bit c, input bit p);
    exp_t       e;
    bit         ok;
    logic [23:0] dflt;
    m_err = 1'b0;
    if (r) begin
      dflt = 24'h703262;
      m_st = M_IDLE; m_pos = 0; m_fail = 0; m_lk = 0; m_sd = 4'd0;
      for (int i = 0; i < 6; i++) m_code[i] = dflt[23-4*i -: 4];
    end else if (m_st == M_LOCK) begin
      if (m_lk == 0) begin
        m_st = M_IDLE; m_pos = 0; m_fail = 0;
      end else begin
        m_lk--;
      end
    end else if (c) begin
      m_st = M_IDLE; m_pos = 0;
    end else if (p && PROG_EN && m_st == M_OPEN) begin
      m_st = M_PROG; m_pos = 0;
    end else if (v) begin
      if (dd > 4'd9) begin
        m_err = 1'b1;
      end else if (m_st == M_IDLE || m_st == M_ENTER) begin
        m_sd = dd;
        m_entry[m_pos] = dd;
        m_pos++;
        m_st = M_ENTER;
        if (m_pos == 6) begin
          ok = 1'b1;
          for (int i = 0; i < 6; i++) if (m_entry[i] != m_code[i]) ok = 1'b0;
          if (ok) begin
            m_st = M_OPEN; m_fail = 0;
          end else begin
            m_fail++;
            if (m_fail >= 3) begin
              m_st = M_LOCK; m_lk = 15;
            end else begin
              m_st = M_CLOSED;
            end
          end
        end
      end else if (m_st == M_PROG) begin
        m_sd = dd;
        m_shadow[m_pos] = dd;
        m_pos++;
        if (m_pos == 6) begin
          for (int i = 0; i < 6; i++) m_code[i] = m_shadow[i];
          m_st = M_IDLE; m_pos = 0;
        end
      end
    end
    case (m_st)
      M_ENTER:  e.msg = 3'd1;
      M_OPEN:   e.msg = 3'd2;
      M_CLOSED: e.msg = 3'd3;
      M_LOCK:   e.msg = 3'd5;
      M_PROG:   e.msg = 3'd6;
      default:  e.msg = 3'd0;
    endcase
    if (m_err) e.msg = 3'd4;
    e.sd  = m_sd;
    e.pos = 3'(m_pos);
    e.fc  = 2'(m_fail);
    e.un  = (m_st == M_OPEN) || (m_st == M_PROG);
    e.err = m_err;
    q.push_back(e);
  endtask

  // Drive one cycle of inputs, advance one edge and score the DUT outputs.
  task automatic step(input bit r, input bit v, input logic [3:0] dd, input bit c, input bit p);
    exp_t e;
    rst = r; dv = v; d = dd; clr = c; pr = p;
    model(r, v, dd, c, p);
    @(posedge clk);
    #1;
    n_step++;
    e = q.pop_front();
    check("msg",        8'(msg),        8'(e.msg));
    check("show_digit", 8'(show_digit), 8'(e.sd));
    check("pos",        8'(pos),        8'(e.pos));
    check("fail_cnt",   8'(fail_cnt),   8'(e.fc));
    check("unlocked",   8'(unlocked),   8'(e.un));
    check("err",        8'(err),        8'(e.err));
  endtask

  task automatic enter(input logic [23:0] c);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, c[23-4*i -: 4], 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; dv = 1'b0; d = 4'd0; clr = 1'b0; pr = 1'b0;
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    idle(1);

    // Correct entry opens
    enter(24'h703262);
    idle(2);
    do_clear();

    // Early mismatch still consumes all six digits, then CLOSED
    enter(24'h713262);
    idle(1);
    do_clear();

    // clear together with a digit in ENTER drops the digit
    step(1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
    idle(1);

    // Illegal digit mid-entry, then finish to OPEN
    step(1'b0, 1'b1, 4'd7,  1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd0,  1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd12, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd3,  1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd2,  1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd6,  1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd2,  1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd15, 1'b0, 1'b0);
    idle(1);
    // prog_req with clear in OPEN goes to IDLE
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);

    // Three failures trigger lockout; inputs ignored throughout
    enter(24'h111111); do_clear();
    enter(24'h111111); do_clear();
    enter(24'h111111);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 4'd7, 1'b1, 1'b1);
    idle(1);

    // Reset after the fourth digit
    step(1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    enter(24'h703262);
    do_clear();

    // Reset in the middle of lockout
    enter(24'h999999); do_clear();
    enter(24'h999999); do_clear();
    enter(24'h999999);
    idle(5);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    enter(24'h703262);
    do_clear();

    // Programming (ignored when the feature is not built)
    enter(24'h703262);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'd10, 1'b0, 1'b0);
    enter(24'h123456);
    idle(1);
    do_clear();
    enter(24'h703262);
    do_clear();
    enter(24'h123456);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'd9, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd8, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
    do_clear();
    enter(24'h123456);
    do_clear();
    // Reset mid-programming restores the factory code
    enter(24'h703262);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'd4, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd4, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    enter(24'h703262);
    idle(1);

    check("scoreboard_empty", 8'(q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lock_controller.md
# lock_controller

Sequencing controller for the DE1-SoC combination-lock datapath. It accepts one decimal digit per strobe, compares a six-digit entry against a stored code, and tracks failed attempts with a timed lockout. It also supports reprogramming the code from the OPEN state. Its `msg`/`show_digit` outputs drive the existing seven-segment message decoder (ERROR, OPEN, CLOSED and so on); the block does no segment encoding itself.

## Interface
- `DIGITS`, 6: code length in digits.
- `MAX_FAIL`, 3: consecutive failed attempts that trigger lockout.
- `LOCKOUT_CYCLES`, 16: clock cycles spent in LOCKOUT.
- `clk`  in  1: the single clock; all state updates on posedge.
- `rst_n`  in  1: reset; synchronous, active-high (asserted when 1).
- `digit_valid`  in  1: one-cycle strobe; `digit` is sampled when this is high.
- `digit`  in  4: entered value; legal range 0–9.
- `clear`  in  1: abandon the current operation and return to IDLE.
- `prog_req`  in  1: request programming mode; honoured only in OPEN.
- `msg`  out  3: display selector. 0 BLANK, 1 DIGIT, 2 OPEN, 3 CLOSED, 4 ERROR, 5 LOCKED, 6 PROG.
- `show_digit`  out  4: last accepted digit, meaningful when `msg`=1 or 6.
- `pos`  out  3: number of digits accepted in the current entry (0..DIGITS).
- `fail_cnt`  out  2: consecutive failed attempts.
- `unlocked`  out  1: high in OPEN and PROG.
- `err`  out  1: one-cycle pulse when an illegal digit (>9) is rejected.

## Operation
- States: IDLE, ENTER, OPEN, CLOSED, LOCKOUT, PROG.
- Code register: DIGITS×4 bits. Reset value is 7,0,3,2,6,2, first digit to last.
- **IDLE**: a legal digit sets `pos`=1 and moves to ENTER.
- **ENTER**: each legal digit increments `pos`.
  - A sticky mismatch flag ORs in (digit != code[pos]).
  - A mismatch never ends entry early; all DIGITS digits are always consumed.
- **End of entry**: on the DIGITS-th digit, go to OPEN if there is no mismatch, otherwise CLOSED.
- **OPEN**: `fail_cnt` clears to 0.
- **CLOSED**: `fail_cnt` increments.
  - If the increment reaches MAX_FAIL, go to LOCKOUT instead of CLOSED; `msg`=5.
- **OPEN/CLOSED exit**: both hold until `clear`, then go to IDLE with `pos`=0.
- **Illegal digits** (>9) in any state:
  - the digit is ignored and `err` pulses;
  - `msg` shows 4 for that cycle only, then reverts to the state's message;
  - `pos` and the mismatch flag are unchanged.
- **LOCKOUT**: counter loads LOCKOUT_CYCLES−1 and decrements each cycle.
  - `digit_valid`, `clear` and `prog_req` are all ignored.
  - At 0: go to IDLE and set `fail_cnt`=0.
- **PROG** (entered from OPEN via `prog_req`):
  - the next DIGITS legal digits fill a shadow register;
  - after the last digit, the shadow is copied to the code register and the state goes to IDLE;
  - `clear` in PROG aborts with the code unchanged.
- **`msg` per state**: IDLE→0; ENTER→1; OPEN→2; CLOSED→3; LOCKOUT→5; PROG→6. The ERROR override (4) lasts one cycle.
- **Priority**: `rst_n` > `clear` > `prog_req` > `digit_valid`.

## Timing
- **Reset**: all outputs are registered. On the cycle after `rst_n` is sampled high:
  - state=IDLE, `msg`=0, `show_digit`=0, `pos`=0, `fail_cnt`=0, `unlocked`=0, `err`=0;
  - code=default and the lockout counter=0.
- Reset mid-PROG discards the shadow; reset mid-LOCKOUT ends the lockout immediately.
- **Latency**: a digit sampled at edge N is reflected in `pos`/`show_digit`/`msg` after edge N.
- The verdict (OPEN/CLOSED/LOCKED) is visible after the same edge that accepted the final digit.
- **Lockout length**: LOCKED is shown for exactly LOCKOUT_CYCLES cycles; IDLE follows on the next cycle.
- **Simultaneous inputs**:
  - `clear` together with `digit_valid` in ENTER gives IDLE with `pos`=0; the digit is dropped.
  - `prog_req` together with `clear` in OPEN gives IDLE.
- `digit_valid` held high for k cycles counts as k digits; the block does no edge detection.
- `fail_cnt` saturates at MAX_FAIL and never wraps.

## Configuration
- Macro `LOCK_PROG_EN`.
- **Defined**: PROG state and `prog_req` are functional as described above.
- **Undefined**:
  - PROG logic and the shadow register are not built, and `prog_req` is ignored;
  - the code stays fixed at 7,0,3,2,6,2;
  - `msg` never equals 6.

## Test plan
- **Correct entry**: reset, then strobe 7,0,3,2,6,2 → `pos` steps 1..6, `msg`=2, `unlocked`=1, `fail_cnt`=0.
- **Early mismatch**: strobe 7,1,3,2,6,2 → `msg` stays 1 through the fifth digit, then 3 after the sixth; `fail_cnt`=1. `clear` → `msg`=0, `pos`=0.
- **Illegal digit**: strobe 7,0,12,3 → `err` pulses once and `msg`=4 for that cycle only; `pos` goes 2 then 3; finishing with 2,6,2 → OPEN.
- **Lockout**: three wrong entries of 1,1,1,1,1,1 → after the third, `msg`=5 for exactly 16 cycles with digits ignored, then `msg`=0, `fail_cnt`=0.
- **Programming** (`LOCK_PROG_EN` defined):
  - open, `prog_req`, enter 1,2,3,4,5,6 → IDLE;
  - 7,0,3,2,6,2 now gives CLOSED and 1,2,3,4,5,6 gives OPEN;
  - repeat with `clear` after the third PROG digit → the old code still opens.
- **Reset mid-operation**: assert `rst_n` after the 4th digit, and again mid-LOCKOUT → next cycle all outputs are at reset values and the default code opens.
